// File: rtl/btf_pipe.sv
// btf_pipe: three-stage pipelined radix-2 FFT butterfly.
//   DIT: y1 = a + b*w, y2 = a - b*w      DIF: y1 = a + b, y2 = (a - b)*w
// Twiddle products are rounded half-up to TFRAC fractional bits. Optional
// per-butterfly halving precedes saturation to DW bits, and a sticky flag
// records any clamped component.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   en              pipeline advance (0 freezes all pipeline registers)
//   in_valid        din1/din2/wn/mode/scale carry a butterfly
//   mode, scale     0=DIT/1=DIF, 1=halve outputs; travel with their data
//   din1, din2      operands a, b packed {imag, real}, DW bits each
//   wn              twiddle packed {imag, real}, TW bits each
//   ovf_clr         clears the sticky overflow flag
//   out_valid       dout1/dout2 hold a fresh butterfly result
//   dout1, dout2    y1, y2 packed {imag, real}
//   ovf             sticky saturation flag
//   bf_cnt          number of valid outputs produced, wraps at 2^16
module btf_pipe #(
  parameter int unsigned DW    = 32,
  parameter int unsigned TW    = 16,
  parameter int unsigned TFRAC = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_valid,
  input  logic            mode,
  input  logic            scale,
  input  logic [2*DW-1:0] din1,
  input  logic [2*DW-1:0] din2,
  input  logic [2*TW-1:0] wn,
  input  logic            ovf_clr,
  output logic            out_valid,
  output logic [2*DW-1:0] dout1,
  output logic [2*DW-1:0] dout2,
  output logic            ovf,
  output logic [15:0]     bf_cnt
);

  // PW holds one data x twiddle product; XW leaves headroom for every S3 sum.
  localparam int unsigned PW = DW + TW;
  localparam int unsigned XW = DW + TW + 3;
  localparam logic signed [XW-1:0] RND  = XW'(1) <<< (TFRAC - 1);
  localparam logic signed [XW-1:0] MAXV = (XW'(1) <<< (DW - 1)) - XW'(1);
  localparam logic signed [XW-1:0] MINV = -MAXV - XW'(1);

  // Round half up, then drop the twiddle fraction.
  function automatic logic signed [XW-1:0] rnd_f(input logic signed [XW-1:0] x);
    rnd_f = (x + RND) >>> TFRAC;
  endfunction

  // Floor-halving when scale is set.
  function automatic logic signed [XW-1:0] scl_f(input logic signed [XW-1:0] x,
                                                 input logic s);
    scl_f = s ? (x >>> 1) : x;
  endfunction

  function automatic logic is_sat(input logic signed [XW-1:0] x);
    is_sat = (x > MAXV) || (x < MINV);
  endfunction

  function automatic logic [DW-1:0] sat_f(input logic signed [XW-1:0] x);
    if (x > MAXV)      sat_f = MAXV[DW-1:0];
    else if (x < MINV) sat_f = MINV[DW-1:0];
    else               sat_f = x[DW-1:0];
  endfunction

  // ---------------- S1: input registers ----------------
  logic            r_s1_vld, r_s1_mode, r_s1_scale;
  logic [2*DW-1:0] r_s1_a, r_s1_b;
  logic [2*TW-1:0] r_s1_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_scale <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_w     <= '0;
    end else if (en) begin
      r_s1_vld   <= in_valid;
      r_s1_mode  <= mode;
      r_s1_scale <= scale;
      r_s1_a     <= din1;
      r_s1_b     <= din2;
      r_s1_w     <= wn;
    end
  end

  logic signed [DW-1:0] w_ar, w_ai, w_br, w_bi;
  logic signed [TW-1:0] w_wr, w_wi;
  assign w_ar = r_s1_a[DW-1:0];
  assign w_ai = r_s1_a[2*DW-1:DW];
  assign w_br = r_s1_b[DW-1:0];
  assign w_bi = r_s1_b[2*DW-1:DW];
  assign w_wr = r_s1_w[TW-1:0];
  assign w_wi = r_s1_w[2*TW-1:TW];

  // ---------------- S2: DIT partial products / DIF sum and difference ----------------
  // Both sets are registered every cycle; S3 picks the one its mode needs.
  logic                 r_s2_vld, r_s2_mode, r_s2_scale;
  logic [2*DW-1:0]      r_s2_a;
  logic [2*TW-1:0]      r_s2_w;
  logic signed [PW-1:0] r_s2_prr, r_s2_pii, r_s2_pri, r_s2_pir;
  logic signed [DW:0]   r_s2_sr, r_s2_si, r_s2_dr, r_s2_di;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_vld   <= 1'b0;
      r_s2_mode  <= 1'b0;
      r_s2_scale <= 1'b0;
      r_s2_a     <= '0;
      r_s2_w     <= '0;
      r_s2_prr   <= '0;
      r_s2_pii   <= '0;
      r_s2_pri   <= '0;
      r_s2_pir   <= '0;
      r_s2_sr    <= '0;
      r_s2_si    <= '0;
      r_s2_dr    <= '0;
      r_s2_di    <= '0;
    end else if (en) begin
      r_s2_vld   <= r_s1_vld;
      r_s2_mode  <= r_s1_mode;
      r_s2_scale <= r_s1_scale;
      r_s2_a     <= r_s1_a;
      r_s2_w     <= r_s1_w;
      r_s2_prr   <= PW'(w_br) * PW'(w_wr);
      r_s2_pii   <= PW'(w_bi) * PW'(w_wi);
      r_s2_pri   <= PW'(w_br) * PW'(w_wi);
      r_s2_pir   <= PW'(w_bi) * PW'(w_wr);
      r_s2_sr    <= (DW+1)'(w_ar) + (DW+1)'(w_br);
      r_s2_si    <= (DW+1)'(w_ai) + (DW+1)'(w_bi);
      r_s2_dr    <= (DW+1)'(w_ar) - (DW+1)'(w_br);
      r_s2_di    <= (DW+1)'(w_ai) - (DW+1)'(w_bi);
    end
  end

  // ---------------- S3: finish arithmetic, scale, saturate ----------------
  logic signed [DW-1:0] w_s2_ar, w_s2_ai;
  logic signed [TW-1:0] w_s2_wr, w_s2_wi;
  assign w_s2_ar = r_s2_a[DW-1:0];
  assign w_s2_ai = r_s2_a[2*DW-1:DW];
  assign w_s2_wr = r_s2_w[TW-1:0];
  assign w_s2_wi = r_s2_w[2*TW-1:TW];

  logic signed [XW-1:0] w_bw_re, w_bw_im, w_dw_re, w_dw_im;
  logic signed [XW-1:0] w_y1r, w_y1i, w_y2r, w_y2i;
  logic                 w_hit;

  always_comb begin
    w_bw_re = rnd_f(XW'(r_s2_prr) - XW'(r_s2_pii));
    w_bw_im = rnd_f(XW'(r_s2_pri) + XW'(r_s2_pir));
    w_dw_re = rnd_f(XW'(r_s2_dr) * XW'(w_s2_wr) - XW'(r_s2_di) * XW'(w_s2_wi));
    w_dw_im = rnd_f(XW'(r_s2_dr) * XW'(w_s2_wi) + XW'(r_s2_di) * XW'(w_s2_wr));
    w_y1r   = XW'(w_s2_ar) + w_bw_re;
    w_y1i   = XW'(w_s2_ai) + w_bw_im;
    w_y2r   = XW'(w_s2_ar) - w_bw_re;
    w_y2i   = XW'(w_s2_ai) - w_bw_im;
    if (r_s2_mode) begin
      w_y1r = XW'(r_s2_sr);
      w_y1i = XW'(r_s2_si);
      w_y2r = w_dw_re;
      w_y2i = w_dw_im;
    end
    w_y1r = scl_f(w_y1r, r_s2_scale);
    w_y1i = scl_f(w_y1i, r_s2_scale);
    w_y2r = scl_f(w_y2r, r_s2_scale);
    w_y2i = scl_f(w_y2i, r_s2_scale);
    w_hit = is_sat(w_y1r) | is_sat(w_y1i) | is_sat(w_y2r) | is_sat(w_y2i);
  end

  // Output registers; dout only changes when a real butterfly lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout1     <= '0;
      dout2     <= '0;
      bf_cnt    <= '0;
      ovf       <= 1'b0;
    end else begin
      if (en) begin
        out_valid <= r_s2_vld;
        if (r_s2_vld) begin
          dout1  <= {sat_f(w_y1i), sat_f(w_y1r)};
          dout2  <= {sat_f(w_y2i), sat_f(w_y2r)};
          bf_cnt <= bf_cnt + 16'd1;
        end
      end
      // A new saturation beats a coincident clear.
      if (en && r_s2_vld && w_hit) ovf <= 1'b1;
      else if (ovf_clr)            ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btf_pipe.sv
// tb_btf_pipe: directed and randomized checks of btf_pipe against a
// longint-arithmetic butterfly model with a latency-tagged expectation queue.
module tb_btf_pipe;

  localparam int unsigned DW    = 32;
  localparam int unsigned TW    = 16;
  localparam int unsigned TFRAC = 14;
  localparam longint LMAX = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint LMIN = -LMAX - 1;

  logic            clk, rst, en, in_valid, mode, scale, ovf_clr;
  logic [2*DW-1:0] din1, din2, dout1, dout2;
  logic [2*TW-1:0] wn;
  logic            out_valid, ovf;
  logic [15:0]     bf_cnt;

  btf_pipe #(.DW(DW), .TW(TW), .TFRAC(TFRAC)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .mode(mode),
    .scale(scale), .din1(din1), .din2(din2), .wn(wn), .ovf_clr(ovf_clr),
    .out_valid(out_valid), .dout1(dout1), .dout2(dout2), .ovf(ovf),
    .bf_cnt(bf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] y1;
    logic [63:0] y2;
    logic        hit;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [63:0] cap1[$];
  logic [63:0] cap2[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          ecnt  = 0;
  logic        exp_ov  = 1'b0;
  logic        exp_ovf = 1'b0;
  logic [63:0] exp_d1  = '0;
  logic [63:0] exp_d2  = '0;
  logic [15:0] exp_cnt = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic longint rnd_tw(input longint x);
    return (x + (longint'(1) <<< (TFRAC - 1))) >>> TFRAC;
  endfunction

  // Butterfly computed straight from the mathematical definition.
  function automatic exp_t model(input logic m, input logic s,
                                 input longint ar, input longint ai,
                                 input longint br, input longint bi,
                                 input longint wr, input longint wi);
    longint y[4];
    longint pr, pim, dr, di;
    exp_t   e;
    if (!m) begin
      pr   = rnd_tw(br * wr - bi * wi);
      pim  = rnd_tw(br * wi + bi * wr);
      y[0] = ar + pr;  y[1] = ai + pim;
      y[2] = ar - pr;  y[3] = ai - pim;
    end else begin
      dr   = ar - br;  di = ai - bi;
      y[0] = ar + br;  y[1] = ai + bi;
      y[2] = rnd_tw(dr * wr - di * wi);
      y[3] = rnd_tw(dr * wi + di * wr);
    end
    e.hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (s) y[k] = y[k] >>> 1;
      if (y[k] > LMAX) begin y[k] = LMAX; e.hit = 1'b1; end
      else if (y[k] < LMIN) begin y[k] = LMIN; e.hit = 1'b1; end
    end
    e.y1  = {y[1][DW-1:0], y[0][DW-1:0]};
    e.y2  = {y[3][DW-1:0], y[2][DW-1:0]};
    e.due = 0;
    return e;
  endfunction

  // One clock: drive inputs, update expectations for the edge, check after it.
  task automatic step(input logic e, input logic v, input logic m, input logic s,
                      input longint ar, input longint ai, input longint br,
                      input longint bi, input longint wr, input longint wi,
                      input logic clr);
    exp_t nx, hd;
    logic emit;
    en = e; in_valid = v; mode = m; scale = s; ovf_clr = clr;
    din1 = {ai[DW-1:0], ar[DW-1:0]};
    din2 = {bi[DW-1:0], br[DW-1:0]};
    wn   = {wi[TW-1:0], wr[TW-1:0]};
    @(posedge clk);
    emit = 1'b0;
    hd.hit = 1'b0;
    if (e) begin
      ecnt++;
      if (v) begin
        nx = model(m, s, ar, ai, br, bi, wr, wi);
        nx.due = ecnt + 2;
        q.push_back(nx);
      end
      if (q.size() > 0 && q[0].due == ecnt) begin
        emit = 1'b1;
        hd = q.pop_front();
        exp_d1 = hd.y1;
        exp_d2 = hd.y2;
        exp_cnt++;
      end
      exp_ov = emit;
    end
    if (emit && hd.hit) exp_ovf = 1'b1;
    else if (clr)       exp_ovf = 1'b0;
    #1;
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    chk("ovf", 64'(ovf), 64'(exp_ovf));
    chk("bf_cnt", 64'(bf_cnt), 64'(exp_cnt));
    if (exp_ov) begin
      chk("dout1", dout1, exp_d1);
      chk("dout2", dout2, exp_d2);
    end
    if (e && out_valid) begin
      cap1.push_back(dout1);
      cap2.push_back(dout2);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
  endtask

  function automatic longint rdat();
    if ($urandom_range(0, 3) == 0) return longint'(int'($urandom));
    return longint'($urandom_range(0, 4000)) - 2000;
  endfunction

  function automatic longint rtw();
    return longint'(shortint'($urandom));
  endfunction

  // Assert rst between edges, check the immediate clear, then release.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dout1", dout1, 64'd0);
    chk("rst_dout2", dout2, 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_bf_cnt", 64'(bf_cnt), 64'd0);
    q.delete();
    exp_ov = 1'b0; exp_ovf = 1'b0; exp_cnt = '0; exp_d1 = '0; exp_d2 = '0;
    en = 1'b1; in_valid = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; mode = 1'b0; scale = 1'b0;
    ovf_clr = 1'b0; din1 = '0; din2 = '0; wn = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("init_out_valid", 64'(out_valid), 64'd0);
    chk("init_dout1", dout1, 64'd0);
    chk("init_ovf", 64'(ovf), 64'd0);
    chk("init_bf_cnt", 64'(bf_cnt), 64'd0);

    // DIT basic
    cap1.delete(); cap2.delete();
    step(1, 1, 0, 0, 500, 0, 0, -500, 16384, 0, 0);
    idle(3);
    chk("dit_y1", cap1[0], 64'hFFFFFE0C_000001F4);
    chk("dit_y2", cap2[0], 64'h000001F4_000001F4);

    // DIT rounding
    cap1.delete(); cap2.delete();
    step(1, 1, 0, 0, 0, 0, -50, 0, 11584, 0, 0);
    idle(3);
    chk("rnd_y1", cap1[0], 64'h00000000_FFFFFFDD);
    chk("rnd_y2", cap2[0], 64'h00000000_00000023);

    // DIF unscaled then scaled, back to back
    cap1.delete(); cap2.delete();
    step(1, 1, 1, 0, 300, 0, 100, 0, 0, -16384, 0);
    step(1, 1, 1, 1, 300, 0, 100, 0, 0, -16384, 0);
    idle(3);
    chk("dif_y1", cap1[0], 64'h00000000_00000190);
    chk("dif_y2", cap2[0], 64'hFFFFFF38_00000000);
    chk("dif_s_y1", cap1[1], 64'h00000000_000000C8);
    chk("dif_s_y2", cap2[1], 64'hFFFFFF9C_00000000);

    // DIT -> DIF -> DIT back to back
    step(1, 1, 0, 0, rdat(), rdat(), rdat(), rdat(), rtw(), rtw(), 0);
    step(1, 1, 1, 0, rdat(), rdat(), rdat(), rdat(), rtw(), rtw(), 0);
    step(1, 1, 0, 1, rdat(), rdat(), rdat(), rdat(), rtw(), rtw(), 0);
    idle(3);

    // Saturation, persistence, clear, clear coincident with new saturation
    cap1.delete(); cap2.delete();
    step(1, 1, 0, 0, 64'sd2147483647, 0, 1, 0, 16384, 0, 0);
    idle(4);
    chk("sat_y1", cap1[0], 64'h00000000_7FFFFFFF);
    chk("sat_y2", cap2[0], 64'h00000000_7FFFFFFE);
    chk("sat_ovf", 64'(ovf), 64'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("clr_ovf", 64'(ovf), 64'd0);
    step(1, 1, 0, 0, 64'sd2147483647, 0, 1, 0, 16384, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("set_beats_clr", 64'(ovf), 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("clr_while_stalled", 64'(ovf), 64'd0);

    // Stall: four inputs, en low for two cycles mid-stream
    async_reset();
    cap1.delete(); cap2.delete();
    step(1, 1, 0, 0, rdat(), rdat(), rdat(), rdat(), rtw(), rtw(), 0);
    step(1, 1, 1, 0, rdat(), rdat(), rdat(), rdat(), rtw(), rtw(), 0);
    step(0, 1, 0, 0, rdat(), rdat(), rdat(), rdat(), rtw(), rtw(), 0);
    step(0, 1, 1, 1, rdat(), rdat(), rdat(), rdat(), rtw(), rtw(), 0);
    step(1, 1, 0, 1, rdat(), rdat(), rdat(), rdat(), rtw(), rtw(), 0);
    step(1, 1, 1, 1, rdat(), rdat(), rdat(), rdat(), rtw(), rtw(), 0);
    idle(4);
    chk("stall_count", 64'(cap1.size()), 64'd4);
    chk("stall_bf_cnt", 64'(bf_cnt), 64'd4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           1'($urandom), 1'($urandom),
           rdat(), rdat(), rdat(), rdat(), rtw(), rtw(),
           ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end
    idle(3);

    // Reset with two butterflies in flight
    step(1, 1, 0, 0, 64'sd2147483647, 0, 1, 0, 16384, 0, 0);
    idle(3);
    step(1, 1, 0, 0, rdat(), rdat(), rdat(), rdat(), rtw(), rtw(), 0);
    step(1, 1, 1, 0, rdat(), rdat(), rdat(), rdat(), rtw(), rtw(), 0);
    async_reset();
    idle(4);
    step(1, 1, 0, 0, 500, 0, 0, -500, 16384, 0, 0);
    idle(3);
    chk("post_rst_bf_cnt", 64'(bf_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
